// File: rtl/input_capture.sv
// input_capture: synchronises and debounces the board pushbuttons, reports
// debounced levels and rising-edge pulses, and captures the switch byte on an
// enter-key press. The captured byte is offered to the consumer through a
// valid/ack handshake.
module input_capture #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int DATA_W          = 8,
  parameter int ENTER_KEY       = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        key_n,
  input  logic [DATA_W-1:0] sw,
  output logic [3:0]        gpi,
  output logic [3:0]        gpi_rise,
  output logic [DATA_W-1:0] din,
  output logic              din_val,
  input  logic              din_ack,
  output logic              overrun,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_VALID    = 2'd1,
    ST_WAIT_REL = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  // Synchroniser stages
  logic [3:0]        key_meta_r;
  logic [3:0]        key_sync_r;
  logic [DATA_W-1:0] sw_meta_r;
  logic [DATA_W-1:0] sw_sync_r;
  logic [3:0]        key_s;
  logic [DATA_W-1:0] sw_s;

  // Debounce state
  logic [3:0][CNT_W-1:0] cnt_r;
  logic [3:0][CNT_W-1:0] cnt_next_s;
  logic [3:0]            gpi_r;
  logic [3:0]            gpi_next_s;
  logic [3:0]            gpi_rise_r;
  logic                  enter_rise_s;

  // Capture FSM and its registered outputs
  state_t            state_r;
  state_t            state_next_s;
  logic [DATA_W-1:0] din_r;
  logic [DATA_W-1:0] din_next_s;
  logic              din_val_r;
  logic              din_val_next_s;
  logic              overrun_r;
  logic              overrun_next_s;
  logic              busy_r;

  // Keys are active-low on the pins; present them active-high internally.
  assign key_s        = ~key_sync_r;
  assign sw_s         = sw_sync_r;
  assign enter_rise_s = gpi_rise_r[ENTER_KEY];

  // Two-flop synchronisers; reset loads the idle pin levels so no false press appears.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_meta_r <= 4'hF;
      key_sync_r <= 4'hF;
      sw_meta_r  <= {DATA_W{1'b0}};
      sw_sync_r  <= {DATA_W{1'b0}};
    end else begin
      key_meta_r <= key_n;
      key_sync_r <= key_meta_r;
      sw_meta_r  <= sw;
      sw_sync_r  <= sw_meta_r;
    end
  end

  // Per-key debounce: a new level is accepted only after it has differed for a full count.
  always_comb begin
    gpi_next_s = gpi_r;
    cnt_next_s = cnt_r;
    for (int i = 0; i < 4; i++) begin
      if (key_s[i] == gpi_r[i]) begin
        cnt_next_s[i] = CNT_ZERO;
      end else if (cnt_r[i] == CNT_LAST) begin
        gpi_next_s[i] = key_s[i];
        cnt_next_s[i] = CNT_ZERO;
      end else begin
        cnt_next_s[i] = cnt_r[i] + CNT_ONE;
      end
    end
  end

  // Debounce registers; the rise pulse is registered alongside the level so both change together.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r      <= {4{CNT_ZERO}};
      gpi_r      <= 4'h0;
      gpi_rise_r <= 4'h0;
    end else begin
      cnt_r      <= cnt_next_s;
      gpi_r      <= gpi_next_s;
      gpi_rise_r <= gpi_next_s & ~gpi_r;
    end
  end

  // Capture FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Capture FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (enter_rise_s) begin
          state_next_s = ST_VALID;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_VALID: begin
        if (din_ack) begin
          // Key still held after ack: wait for release so one press gives one value.
          if (gpi_r[ENTER_KEY]) begin
            state_next_s = ST_WAIT_REL;
          end else begin
            state_next_s = ST_IDLE;
          end
        end else begin
          state_next_s = ST_VALID;
        end
      end
      ST_WAIT_REL: begin
        if (!gpi_r[ENTER_KEY]) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_WAIT_REL;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Capture FSM output logic: next values for the registered handshake outputs.
  always_comb begin
    din_next_s     = din_r;
    din_val_next_s = din_val_r;
    overrun_next_s = overrun_r;
    case (state_r)
      ST_IDLE: begin
        if (enter_rise_s) begin
          din_next_s     = sw_s;
          din_val_next_s = 1'b1;
        end else begin
          din_val_next_s = 1'b0;
        end
      end
      ST_VALID: begin
        if (din_ack) begin
          din_val_next_s = 1'b0;
        end else begin
          din_val_next_s = 1'b1;
        end
        // A second press while a value is pending is flagged; din is left untouched.
        if (enter_rise_s) begin
          overrun_next_s = 1'b1;
        end else begin
          overrun_next_s = overrun_r;
        end
      end
      ST_WAIT_REL: begin
        din_val_next_s = 1'b0;
      end
      default: begin
        din_val_next_s = 1'b0;
      end
    endcase
  end

  // Registered handshake outputs; busy tracks the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      din_r     <= {DATA_W{1'b0}};
      din_val_r <= 1'b0;
      overrun_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      din_r     <= din_next_s;
      din_val_r <= din_val_next_s;
      overrun_r <= overrun_next_s;
      busy_r    <= (state_next_s != ST_IDLE);
    end
  end

  assign gpi      = gpi_r;
  assign gpi_rise = gpi_rise_r;
  assign din      = din_r;
  assign din_val  = din_val_r;
  assign overrun  = overrun_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_input_capture.sv
// tb_input_capture: directed scenarios plus randomized key/switch/ack
// traffic, checked every cycle against a behavioural model of the block.
module tb_input_capture;

  localparam int DEB = 4;
  localparam int EK  = 0;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] key_n;
  logic [7:0] sw;
  logic       din_ack;
  logic [3:0] gpi;
  logic [3:0] gpi_rise;
  logic [7:0] din;
  logic       din_val;
  logic       overrun;
  logic       busy;

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  input_capture #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W(3),
    .DATA_W(8),
    .ENTER_KEY(EK)
  ) dut (
    .clk(clk),
    .reset(reset),
    .key_n(key_n),
    .sw(sw),
    .gpi(gpi),
    .gpi_rise(gpi_rise),
    .din(din),
    .din_val(din_val),
    .din_ack(din_ack),
    .overrun(overrun),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // k1/k2 and s1/s2 are the raw pin values seen one and two edges ago.
  // run[i] counts consecutive edges on which the synced key disagreed with gpi.
  // pending = a captured value not yet acked; waitrel = acked while key still held.
  typedef struct packed {
    logic [3:0]      k1;
    logic [3:0]      k2;
    logic [7:0]      s1;
    logic [7:0]      s2;
    logic [3:0]      gpi;
    logic [3:0]      rise;
    logic [3:0][7:0] run;
    logic [7:0]      din;
    logic            dval;
    logic            ovr;
    logic            pending;
    logic            waitrel;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t step(input mstate_t c, input logic rst, input logic [3:0] kn,
                                   input logic [7:0] s, input logic ack);
    mstate_t    n;
    logic [3:0] keys;
    n = c;
    if (rst) begin
      n    = '0;
      n.k1 = 4'hF;
      n.k2 = 4'hF;
      return n;
    end
    keys = ~c.k2;
    // handshake, driven by last cycle's visible gpi / rise
    if (c.pending) begin
      if (c.rise[EK]) n.ovr = 1'b1;
      if (ack) begin
        n.dval    = 1'b0;
        n.pending = 1'b0;
        n.waitrel = c.gpi[EK];
      end
    end else if (c.waitrel) begin
      if (!c.gpi[EK]) n.waitrel = 1'b0;
    end else if (c.rise[EK]) begin
      n.din     = c.s2;
      n.dval    = 1'b1;
      n.pending = 1'b1;
    end
    // debounce: accept a level after DEB consecutive disagreeing edges
    for (int i = 0; i < 4; i++) begin
      if (keys[i] != c.gpi[i]) begin
        n.run[i] = c.run[i] + 8'd1;
        if (int'(n.run[i]) == DEB) begin
          n.gpi[i] = keys[i];
          n.run[i] = 8'd0;
        end
      end else begin
        n.run[i] = 8'd0;
      end
    end
    n.rise = n.gpi & ~c.gpi;
    n.k2 = c.k1;
    n.k1 = kn;
    n.s2 = c.s1;
    n.s1 = s;
    return n;
  endfunction

  always @(posedge clk) m <= step(m, reset, key_n, sw, din_ack);

  // compare every output against the model each cycle
  always @(negedge clk) begin
    if (check_en) begin
      check("gpi", {28'd0, gpi}, {28'd0, m.gpi});
      check("gpi_rise", {28'd0, gpi_rise}, {28'd0, m.rise});
      check("din", {24'd0, din}, {24'd0, m.din});
      check("din_val", {31'd0, din_val}, {31'd0, m.dval});
      check("overrun", {31'd0, overrun}, {31'd0, m.ovr});
      check("busy", {31'd0, busy}, {31'd0, (m.pending | m.waitrel)});
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_gpi(input int idx, input logic lvl, output int n);
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (gpi[idx] === lvl) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic cycles(input int c);
    repeat (c) @(negedge clk);
  endtask

  int         n;
  int         width;
  logic [7:0] got;

  initial begin
    reset   = 1'b1;
    key_n   = 4'hF;
    sw      = 8'h00;
    din_ack = 1'b0;
    cycles(2);
    check_en = 1'b1;
    reset    = 1'b0;

    // idle after reset
    cycles(20);
    check("t1_idle", {gpi, gpi_rise, din, 5'd0, din_val, overrun, busy}, 32'd0);

    // first capture with latency measurement
    sw       = 8'hA5;
    key_n[0] = 1'b0;
    wait_gpi(0, 1'b1, n);
    check("t2_latency", n, 32'd6);
    check("t2_rise", {28'd0, gpi_rise}, 32'd1);
    cycles(1);
    check("t2_rise_gone", {28'd0, gpi_rise}, 32'd0);
    check("t2_dval", {31'd0, din_val}, 32'd1);
    check("t2_din", {24'd0, din}, 32'hA5);
    sw = 8'h5A;
    cycles(10);
    check("t2_hold_dval", {31'd0, din_val}, 32'd1);
    check("t2_hold_din", {24'd0, din}, 32'hA5);
    din_ack = 1'b1;
    cycles(1);
    din_ack = 1'b0;
    check("t2_ack_dval", {31'd0, din_val}, 32'd0);
    check("t2_waitrel_busy", {31'd0, busy}, 32'd1);
    key_n[0] = 1'b1;
    cycles(5);
    check("t2_busy_until_release", {31'd0, busy}, 32'd1);
    cycles(5);
    check("t2_busy_cleared", {31'd0, busy}, 32'd0);

    // bouncing key 2
    key_n[2] = 1'b0;
    cycles(2);
    key_n[2] = 1'b1;
    cycles(2);
    check("t3_no_early_gpi", {28'd0, gpi}, 32'd0);
    key_n[2] = 1'b0;
    wait_gpi(2, 1'b1, n);
    check("t3_latency", n, 32'd6);
    check("t3_rise", {28'd0, gpi_rise}, 32'h4);
    cycles(1);
    check("t3_single_pulse", {28'd0, gpi_rise}, 32'd0);
    check("t3_no_capture", {31'd0, din_val}, 32'd0);
    key_n[2] = 1'b1;
    cycles(10);

    // overrun
    sw       = 8'h3C;
    key_n[0] = 1'b0;
    cycles(8);
    check("t4_din", {24'd0, din}, 32'h3C);
    key_n[0] = 1'b1;
    cycles(8);
    sw       = 8'h77;
    key_n[0] = 1'b0;
    cycles(8);
    check("t4_overrun", {31'd0, overrun}, 32'd1);
    check("t4_din_kept", {24'd0, din}, 32'h3C);
    din_ack = 1'b1;
    cycles(1);
    din_ack = 1'b0;
    check("t4_ack_dval", {31'd0, din_val}, 32'd0);
    key_n[0] = 1'b1;
    cycles(10);
    check("t4_overrun_sticky", {31'd0, overrun}, 32'd1);

    // reset mid-handshake
    sw       = 8'h11;
    key_n[0] = 1'b0;
    cycles(8);
    check("t5_dval_before", {31'd0, din_val}, 32'd1);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    check("t5_reset_state", {gpi, gpi_rise, din, 5'd0, din_val, overrun, busy}, 32'd0);
    cycles(8);
    check("t5_recapture_dval", {31'd0, din_val}, 32'd1);
    check("t5_recapture_din", {24'd0, din}, 32'h11);
    din_ack = 1'b1;
    cycles(1);
    din_ack = 1'b0;
    key_n[0] = 1'b1;
    cycles(10);

    // ack tied high: one single-cycle pulse per press
    din_ack = 1'b1;
    for (int v = 1; v <= 3; v++) begin
      sw       = 8'(v);
      key_n[0] = 1'b0;
      width    = 0;
      got      = 8'h00;
      for (int k = 0; k < 18; k++) begin
        if (k == 9) key_n[0] = 1'b1;
        @(negedge clk);
        if (din_val === 1'b1) begin
          width++;
          got = din;
        end
      end
      check("t6_width", width, 32'd1);
      check("t6_value", {24'd0, got}, v);
    end
    check("t6_no_overrun", {31'd0, overrun}, 32'd0);
    din_ack = 1'b0;

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) begin
        n = $urandom_range(0, 3);
        key_n[n] = ~key_n[n];
      end
      sw      = 8'($urandom);
      din_ack = ($urandom_range(0, 3) == 0);
      reset   = ($urandom_range(0, 399) == 0);
    end
    @(negedge clk);
    reset = 1'b0;
    cycles(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/input_capture.md
Name: input_capture

Overview:
- Input-side counterpart of the SoC's dout/dval display path: turns raw pushbuttons and switches into clean, synchronised inputs for the SoC.
- Synchronises and debounces the active-low pushbuttons and presents them as active-high levels plus one-cycle rising-edge pulses (gpi path).
- On a press of the designated enter key, captures the synchronised switch byte and offers it to the SoC through a valid/ack handshake (din path).
- Sits between the board pins (KEY, SW) and the soc instance in top.

Parameters:
- DEBOUNCE_CYCLES, 1000000, number of consecutive stable cycles needed before a key level is accepted (20 ms at 50 MHz); legal range >= 2.
- CNT_W, 20, width of each debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- DATA_W, 8, width of the switch bus and the captured data.
- ENTER_KEY, 0, index of the key that triggers a data capture (0..3).

Ports:
- clk, input, 1, system clock (50 MHz).
- reset, input, 1, synchronous active-high reset.
- key_n, input, 4, raw pushbuttons, active-low, asynchronous to clk.
- sw, input, DATA_W, raw switches, asynchronous to clk.
- gpi, output, 4, debounced key levels, active-high.
- gpi_rise, output, 4, one-cycle pulse per debounced 0->1 transition.
- din, output, DATA_W, captured switch value.
- din_val, output, 1, din holds an unconsumed value.
- din_ack, input, 1, consumer accepts din; sampled only while din_val=1.
- overrun, output, 1, sticky flag: an enter press arrived while a value was still pending.
- busy, output, 1, capture FSM not in IDLE.

Behaviour:
- Reset (synchronous, reset=1 at a clk edge):
  - All outputs go to 0.
  - Synchronisers are loaded with the idle level: key_n sync = 1 (released), sw sync = 0.
  - Debounce counters are cleared; FSM goes to IDLE.
  - Reset mid-handshake drops din_val immediately; a pending value is discarded.
- Synchronisers:
  - Two flip-flop stages on each key_n bit and on each sw bit.
  - key_s = ~key_n after two stages.
  - sw_s = sw after two stages.
- Debounce, per key i:
  - If key_s[i] == gpi[i]: cnt[i] <= 0.
  - Otherwise cnt[i] increments. On the edge where cnt[i] == DEBOUNCE_CYCLES-1: gpi[i] <= key_s[i] and cnt[i] <= 0.
  - Any bounce back to the gpi level before the count completes restarts the count from 0.
  - Latency from a clean raw edge to the gpi change: 2 + DEBOUNCE_CYCLES clk edges.
- gpi_rise[i] = gpi[i] & ~gpi_q[i], where gpi_q is gpi delayed one cycle. High for exactly the first cycle gpi[i] reads 1. Falling edges produce no pulse.
- Capture FSM:
  - IDLE: on gpi_rise[ENTER_KEY]: din <= sw_s, din_val <= 1, go to VALID. din_val is therefore asserted one cycle after gpi_rise.
  - VALID: din and din_val are held stable.
    - On an edge with din_ack=1: din_val <= 0. Go to WAIT_REL if gpi[ENTER_KEY]=1, else IDLE.
    - A gpi_rise[ENTER_KEY] while in VALID: overrun <= 1; din is not overwritten.
    - If ack and that rise occur on the same edge: the ack is honoured and overrun is set.
  - WAIT_REL: stay until gpi[ENTER_KEY]=0, then go to IDLE. A rise seen in WAIT_REL is ignored; that cannot normally occur without a preceding release.
- Handshake:
  - din_ack while din_val=0 is ignored.
  - din_ack held high continuously consumes exactly one value per capture; din_val is high for a minimum of 1 cycle.
- overrun clears only on reset.
- busy = (state != IDLE).
- Non-enter keys never affect din, din_val or the FSM.
- sw changes after capture do not alter din.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset release, all keys up (key_n=4'hF), sw=8'h00 -> gpi=0, gpi_rise=0, din=0, din_val=0, overrun=0, busy=0 for 20 cycles.
- sw=8'hA5; key_n[0] driven low and held -> gpi[0] rises exactly 6 edges after the drive; gpi_rise[0] is high for 1 cycle; din=8'hA5 and din_val=1 on the next cycle. Holding din_ack=0 for 10 cycles keeps din and din_val unchanged. A 1-cycle din_ack then gives din_val=0 on the next edge and busy=1 (WAIT_REL) until the key is released and debounced.
- key_n[2] bounces low/high/low with a 2-cycle spacing, then holds low -> gpi[2] rises only 6 edges after the final transition; a single gpi_rise[2] pulse; din_val stays 0.
- Capture 8'h3C with no ack; release and re-press key 0 -> overrun=1, din still 8'h3C. After ack, overrun stays 1 until reset.
- Assert reset for 1 cycle while din_val=1 -> on the next edge din_val=0, busy=0, din=0, gpi=0 even with key 0 still held. After reset, the held key debounces to gpi[0]=1 and produces a fresh capture.
- din_ack tied high throughout; three separate key-0 presses with sw=8'h01, 8'h02, 8'h03 -> three din_val pulses, each 1 cycle wide, carrying 8'h01, 8'h02, 8'h03 in order; overrun=0.
